// File: rtl/cpu_pkg.sv
// Shared CPU datapath widths, constants and types for the register-file slice.
package cpu_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] reg_addr_t;

    localparam word_t     ZERO_WORD    = 32'h0000_0000;
    localparam reg_addr_t NOP_REG_ADDR = 5'd0;

endpackage : cpu_pkg

// File: rtl/hilo_reg.sv
// HI/LO register pair with write-through bypass toward EX.
module hilo_reg
    import cpu_pkg::*;
#(
    parameter int DATA_W = cpu_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [DATA_W-1:0] hi_i,
    input  logic [DATA_W-1:0] lo_i,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] hi_d;
    logic [DATA_W-1:0] lo_q;
    logic [DATA_W-1:0] lo_d;

    // Next-state: both halves load together so HI/LO never disagree.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (we_i) begin
            hi_d = hi_i;
            lo_d = lo_i;
        end else begin
            hi_d = hi_q;
            lo_d = lo_q;
        end
    end

    // HI/LO storage, cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_q <= {DATA_W{1'b0}};
            lo_q <= {DATA_W{1'b0}};
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    // Bypass ignores rst so EX sees in-flight HI/LO even during reset.
    always_comb begin
        hi_o = hi_q;
        lo_o = lo_q;
        if (we_i) begin
            hi_o = hi_i;
            lo_o = lo_i;
        end else begin
            hi_o = hi_q;
            lo_o = lo_q;
        end
    end

endmodule : hilo_reg

// File: rtl/wb_regfile.sv
// Write-back endpoint: GPR file, HI/LO pair and bypassed read ports.
// Optional retire counter enabled by defining WB_RETIRE_CNT_EN.
module wb_regfile
    import cpu_pkg::*;
#(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int NREGS  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] wb_wd,
    input  logic              wb_wreg,
    input  logic [DATA_W-1:0] wb_wdata,
    input  logic [DATA_W-1:0] wb_hi,
    input  logic [DATA_W-1:0] wb_lo,
    input  logic              wb_whilo,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
`ifdef WB_RETIRE_CNT_EN
    ,
    input  logic              retire_clr,
    output logic [31:0]       retire_cnt
`endif
);

    logic [DATA_W-1:0] gpr_q [NREGS];
    logic              gpr_we_s;

    // Port priority: disabled, $0, in-flight write, then stored value.
    function automatic logic [DATA_W-1:0] rd_sel(
        input logic              re,
        input logic [ADDR_W-1:0] ra,
        input logic              wreg,
        input logic [ADDR_W-1:0] wd,
        input logic [DATA_W-1:0] wdata,
        input logic [DATA_W-1:0] stored
    );
        if (!re) begin
            return {DATA_W{1'b0}};
        end else if (ra == {ADDR_W{1'b0}}) begin
            return {DATA_W{1'b0}};
        end else if (wreg && (wd == ra)) begin
            return wdata;
        end else begin
            return stored;
        end
    endfunction

    assign gpr_we_s = wb_wreg && (wb_wd != {ADDR_W{1'b0}});

    // GPR array; $0 is never written so it stays at its reset value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                gpr_q[i] <= {DATA_W{1'b0}};
            end
        end else if (gpr_we_s) begin
            gpr_q[wb_wd] <= wb_wdata;
        end
    end

    // Combinational read ports toward ID.
    always_comb begin
        rdata1 = rd_sel(re1, raddr1, wb_wreg, wb_wd, wb_wdata, gpr_q[raddr1]);
        rdata2 = rd_sel(re2, raddr2, wb_wreg, wb_wd, wb_wdata, gpr_q[raddr2]);
    end

    hilo_reg #(
        .DATA_W (DATA_W)
    ) u_hilo (
        .clk  (clk),
        .rst  (rst),
        .we_i (wb_whilo),
        .hi_i (wb_hi),
        .lo_i (wb_lo),
        .hi_o (hi_o),
        .lo_o (lo_o)
    );

`ifdef WB_RETIRE_CNT_EN
    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    // Clear beats increment; the counter wraps naturally at 32 bits.
    always_comb begin
        cnt_d = cnt_q;
        if (retire_clr) begin
            cnt_d = 32'd0;
        end else if (gpr_we_s || wb_whilo) begin
            cnt_d = cnt_q + 32'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Retire counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign retire_cnt = cnt_q;
`endif

endmodule : wb_regfile

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back endpoint of the 5-stage MIPS pipeline. It consumes the wb_* bundle launched by the MEM/WB pipeline register and commits it to the architectural state.
- Holds the 32x32 general register file (GPR) and the HI/LO register pair.
- Exposes two GPR read ports for ID and one HI/LO read port for EX, each with same-cycle write-back bypass.
- Sits after mem_wb; reads feed id and ex.

Parameters:
- DATA_W, 32, width of a GPR and of HI and LO (matches RegBus).
- ADDR_W, 5, GPR address width (matches RegAddrBus).
- NREGS, 32, number of GPRs; must equal 2**ADDR_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low: asserted when 0, released synchronously by upstream logic.
- wb_wd  in  ADDR_W  GPR write address.
- wb_wreg  in  1  GPR write enable.
- wb_wdata  in  DATA_W  GPR write data.
- wb_hi  in  DATA_W  HI write data.
- wb_lo  in  DATA_W  LO write data.
- wb_whilo  in  1  HI/LO write enable (writes both).
- re1  in  1  read enable, port 1.
- raddr1  in  ADDR_W  read address, port 1.
- rdata1  out  DATA_W  read data, port 1.
- re2  in  1  read enable, port 2.
- raddr2  in  ADDR_W  read address, port 2.
- rdata2  out  DATA_W  read data, port 2.
- hi_o  out  DATA_W  current HI, with bypass.
- lo_o  out  DATA_W  current LO, with bypass.

Behaviour:
- Reset (rst==0, asynchronous):
  - All GPRs, HI and LO clear to 0 immediately, regardless of clk.
  - Because the outputs are combinational views, rdata1/rdata2/hi_o/lo_o read 0 during reset, unless a bypass path is active.
  - Reset asserted mid-write wins: no write lands on an edge where rst==0.
- GPR write: on posedge clk with rst==1, if wb_wreg==1 and wb_wd!=0, then GPR[wb_wd] <= wb_wdata.
- $0: writes to address 0 are silently dropped; GPR[0] reads 0 always.
- HI/LO write: on posedge clk with rst==1, if wb_whilo==1, then HI <= wb_hi and LO <= wb_lo, atomically.
- GPR and HI/LO writes are independent; both may occur in the same cycle.
- Read ports are combinational, zero latency. Priority for port n (n=1,2):
  1. re_n==0 gives 0.
  2. raddr_n==0 gives 0.
  3. wb_wreg==1 and wb_wd==raddr_n gives wb_wdata (write-through bypass).
  4. Otherwise GPR[raddr_n].
- Both ports may address the same register; each resolves independently. No port conflict exists.
- HI/LO read: hi_o = wb_whilo ? wb_hi : HI; lo_o = wb_whilo ? wb_lo : LO.
- Bubbles from mem_wb (wreg=0, whilo=0, wd=0, data=0) change no state.
- No stall input: mem_wb already converts stalls into bubbles.
- Bypass logic must not use rst. During reset the bypass still reflects the wb_* inputs, but no state is updated.

Optional Feature:
- Macro: WB_RETIRE_CNT_EN.
- Defined:
  - Adds output retire_cnt, 32 bits, reset 0.
  - Increments by 1 on each posedge where rst==1 and (wb_wreg==1 && wb_wd!=0 || wb_whilo==1).
  - Wraps from 0xFFFFFFFF to 0.
  - Adds input retire_clr, 1 bit, synchronous; it clears the counter and has priority over increment.
- Undefined: neither port exists; no counter logic.

Decomposition:
- Package cpu_pkg: DATA_W/ADDR_W constants, the zero-word and NOP-register-address constants, and the reg_addr_t and word_t typedefs.
- One natural sub-module: hilo_reg, holding the HI/LO storage and its bypass mux.
- The GPR array, the read muxes and the optional counter stay in wb_regfile.

Test Plan:
- Reset: hold rst=0 for 3 cycles, then release. Read raddr1=5, raddr2=31 with re=1 -> both 0; hi_o=lo_o=0.
- Write then read: write wd=7, wdata=0xDEADBEEF; next cycle raddr1=7, re1=1 -> rdata1=0xDEADBEEF.
- Bypass: same cycle wb_wreg=1, wd=3, wdata=0x12345678, raddr1=raddr2=3 -> both ports show 0x12345678 before the edge; the value persists after the edge.
- $0: write wd=0, wdata=0xFFFFFFFF; raddr1=0 -> 0 in the same cycle and afterwards. Also re2=0 with raddr2=7 -> rdata2=0.
- HI/LO: whilo=1, hi=0xA, lo=0xB -> hi_o/lo_o show 0xA/0xB in the same cycle and held afterwards. whilo=0 with hi=0xC -> hi_o stays 0xA.
- Async reset mid-stream: after writing GPR[9]=0x55, drop rst between edges -> rdata1 for addr 9 goes to 0 before the next edge. With WB_RETIRE_CNT_EN, 4 valid writes followed by 1 bubble -> retire_cnt=4.
